// File: rtl/neureka_job_dispatcher_pkg.sv
// Shared types for the multi-engine NEUREKA job dispatcher.
package neureka_job_dispatcher_pkg;

    localparam int NEUREKA_N_ENGINES_DEFAULT = 2;
    localparam int NEUREKA_CORE_W_DEFAULT    = 3;
    localparam int NEUREKA_ID_W_DEFAULT      = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } neureka_dispatch_state_e;

    typedef struct packed {
        logic [NEUREKA_CORE_W_DEFAULT-1:0] core;
        logic [NEUREKA_ID_W_DEFAULT-1:0]   id;
    } neureka_job_t;

    function automatic int neureka_wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/neureka_job_fifo.sv
// Synchronous job FIFO with full/empty/count; push is dropped when full, pop when empty.
module neureka_job_fifo
    import neureka_job_dispatcher_pkg::*;
#(
    parameter type T     = neureka_job_t,
    parameter int  DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    output T                             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = push ? PTR_W'(neureka_wrap_inc(int'(wr_q), DEPTH)) : wr_q;
        rd_d  = pop  ? PTR_W'(neureka_wrap_inc(int'(rd_q), DEPTH)) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/neureka_job_dispatcher.sv
// Queues jobs, hands them round-robin to idle engines, and routes completions back to owning cores.
module neureka_job_dispatcher
    import neureka_job_dispatcher_pkg::*;
#(
    parameter int N_ENGINES     = NEUREKA_N_ENGINES_DEFAULT,
    parameter int N_CORES       = 8,
    parameter int N_CONTEXT     = 4,
    parameter int ID_W          = 8,
    parameter int REGFILE_N_EVT = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    input  logic [$clog2(N_CORES)-1:0]         job_core_i,
    input  logic [ID_W-1:0]                    job_id_i,
    output logic [N_ENGINES-1:0]               eng_start_o,
    input  logic [N_ENGINES-1:0]               eng_done_i,
    output logic [N_ENGINES*ID_W-1:0]          eng_id_o,
    output logic [N_ENGINES-1:0]               running_o,
    output logic [N_ENGINES-1:0]               done_mask_o,
    output logic [N_CORES*REGFILE_N_EVT-1:0]   evt_o,
    output logic                               busy_o
);

    localparam int CORE_W = $clog2(N_CORES);
    localparam int RR_W   = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    typedef struct packed {
        logic [CORE_W-1:0] core;
        logic [ID_W-1:0]   id;
    } job_t;

    job_t                       fifo_in, fifo_head;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(N_CONTEXT+1)-1:0] fifo_count;

    neureka_dispatch_state_e    state_q [N_ENGINES];
    neureka_dispatch_state_e    state_d [N_ENGINES];
    logic [ID_W-1:0]            id_q    [N_ENGINES];
    logic [ID_W-1:0]            id_d    [N_ENGINES];
    logic [CORE_W-1:0]          owner_q [N_ENGINES];
    logic [CORE_W-1:0]          owner_d [N_ENGINES];

    logic [RR_W-1:0]            rr_q, rr_d, disp_sel;
    logic                       disp_en;
    logic [N_ENGINES-1:0]       done_acc, done_mask_q;
    logic [N_CORES-1:0]         evt0_d, evt0_q;
    logic                       evt1_d, evt1_q;
    logic                       busy_now, busy_q;

    assign fifo_in = '{core: job_core_i, id: job_id_i};

    neureka_job_fifo #(
        .T     (job_t),
        .DEPTH (N_CONTEXT)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (job_valid_i),
        .data_i  (fifo_in),
        .pop_i   (disp_en),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign job_ready_o = !fifo_full;

    // Scan downwards so the idle engine closest to rr_q wins.
    always_comb begin
        disp_en  = 1'b0;
        disp_sel = '0;
        if (!fifo_empty) begin
            for (int i = N_ENGINES - 1; i >= 0; i--) begin
                if (state_q[(int'(rr_q) + i) % N_ENGINES] == IDLE) begin
                    disp_en  = 1'b1;
                    disp_sel = RR_W'((int'(rr_q) + i) % N_ENGINES);
                end
            end
        end
        rr_d = disp_en ? RR_W'(neureka_wrap_inc(int'(disp_sel), N_ENGINES)) : rr_q;
    end

    always_comb begin
        busy_now = (fifo_count != '0);
        evt0_d   = '0;
        done_acc = '0;
        for (int e = 0; e < N_ENGINES; e++) begin
            state_d[e] = state_q[e];
            id_d[e]    = id_q[e];
            owner_d[e] = owner_q[e];
            if (state_q[e] != IDLE) busy_now = 1'b1;
            case (state_q[e])
                IDLE: begin
                    if (disp_en && int'(disp_sel) == e) begin
                        state_d[e] = START;
                        id_d[e]    = fifo_head.id;
                        owner_d[e] = fifo_head.core;
                    end
                end
                START: state_d[e] = RUN;
                RUN: begin
                    if (eng_done_i[e]) begin
                        state_d[e]  = IDLE;
                        done_acc[e] = 1'b1;
                        evt0_d[owner_q[e]] = 1'b1;
                    end
                end
                default: state_d[e] = IDLE;
            endcase
        end
        // A fall caused by reset cannot fire: reset clears busy_q.
        evt1_d = busy_q && !busy_now;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int e = 0; e < N_ENGINES; e++) begin
                state_q[e] <= IDLE;
                id_q[e]    <= '0;
                owner_q[e] <= '0;
            end
            rr_q        <= '0;
            done_mask_q <= '0;
            evt0_q      <= '0;
            evt1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            for (int e = 0; e < N_ENGINES; e++) begin
                state_q[e] <= state_d[e];
                id_q[e]    <= id_d[e];
                owner_q[e] <= owner_d[e];
            end
            rr_q        <= rr_d;
            done_mask_q <= done_acc;
            evt0_q      <= evt0_d;
            evt1_q      <= evt1_d;
            busy_q      <= busy_now;
        end
    end

    always_comb begin
        eng_start_o = '0;
        running_o   = '0;
        eng_id_o    = '0;
        evt_o       = '0;
        for (int e = 0; e < N_ENGINES; e++) begin
            eng_start_o[e]              = (state_q[e] == START);
            running_o[e]                = (state_q[e] != IDLE);
            eng_id_o[e*ID_W +: ID_W]    = id_q[e];
        end
        for (int c = 0; c < N_CORES; c++) begin
            evt_o[c*REGFILE_N_EVT]     = evt0_q[c];
            evt_o[c*REGFILE_N_EVT + 1] = evt1_q;
        end
    end

    assign done_mask_o = done_mask_q;
    assign busy_o      = busy_q;

endmodule
